// File: rtl/writeback_arbiter_scoreboard.sv
// writeback_arbiter_scoreboard: round-robin arbiter for the shared register-file write port plus a per-register busy scoreboard.
module writeback_arbiter_scoreboard #(
  parameter int DATA_WIDTH      = 32,
  parameter int REGISTER_AMOUNT = 32,
  parameter int ADDR_WIDTH_RF   = $clog2(REGISTER_AMOUNT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       claim_valid_1,
  input  logic [ADDR_WIDTH_RF-1:0]   claim_addr_1,
  input  logic                       claim_valid_2,
  input  logic [ADDR_WIDTH_RF-1:0]   claim_addr_2,
  input  logic                       wb_req_1,
  input  logic [ADDR_WIDTH_RF-1:0]   wb_addr_1,
  input  logic [DATA_WIDTH-1:0]      wb_data_1,
  output logic                       wb_ack_1,
  input  logic                       wb_req_2,
  input  logic [ADDR_WIDTH_RF-1:0]   wb_addr_2,
  input  logic [DATA_WIDTH-1:0]      wb_data_2,
  output logic                       wb_ack_2,
  output logic                       rf_wr_en,
  output logic [ADDR_WIDTH_RF-1:0]   rf_wr_addr,
  output logic [DATA_WIDTH-1:0]      rf_wr_data,
  output logic [REGISTER_AMOUNT-1:0] busy_register,
  output logic [REGISTER_AMOUNT-1:0] new_data_register,
  output logic                       claim_conflict
);
  logic                       last_q;
  logic                       el_1, el_2, g_1, g_2, gnt, conflict_d;
  logic [ADDR_WIDTH_RF-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]      g_data;
  logic [REGISTER_AMOUNT-1:0] rel, claim, busy_d;
  // last_q = 1 means processor 2 was granted last, so processor 1 wins the next tie
  always_comb begin
    el_1       = wb_req_1 & ~wb_ack_1;
    el_2       = wb_req_2 & ~wb_ack_2;
    g_1        = el_1 & (~el_2 | last_q);
    g_2        = el_2 & ~g_1;
    gnt        = g_1 | g_2;
    g_addr     = g_1 ? wb_addr_1 : wb_addr_2;
    g_data     = g_1 ? wb_data_1 : wb_data_2;
    rel        = (gnt && g_addr != '0) ? REGISTER_AMOUNT'(1) << g_addr : '0;
    claim      = ((claim_valid_1 ? REGISTER_AMOUNT'(1) << claim_addr_1 : '0) |
                  (claim_valid_2 ? REGISTER_AMOUNT'(1) << claim_addr_2 : '0)) & ~REGISTER_AMOUNT'(1);
    busy_d     = (busy_register & ~rel) | claim;
    conflict_d = (claim_valid_1 & claim_valid_2 & (claim_addr_1 == claim_addr_2) & (claim_addr_1 != '0)) |
                 (claim_valid_1 & busy_register[claim_addr_1] & ~rel[claim_addr_1]) |
                 (claim_valid_2 & busy_register[claim_addr_2] & ~rel[claim_addr_2]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q            <= 1'b1;
      wb_ack_1          <= 1'b0;
      wb_ack_2          <= 1'b0;
      rf_wr_en          <= 1'b0;
      rf_wr_addr        <= '0;
      rf_wr_data        <= '0;
      busy_register     <= '0;
      new_data_register <= '0;
      claim_conflict    <= 1'b0;
    end else begin
      wb_ack_1          <= g_1;
      wb_ack_2          <= g_2;
      rf_wr_en          <= gnt && g_addr != '0;
      new_data_register <= rel;
      busy_register     <= busy_d;
      claim_conflict    <= conflict_d;
      if (gnt) begin
        last_q     <= g_2;
        rf_wr_addr <= g_addr;
        rf_wr_data <= g_data;
      end
    end
  end
endmodule

// File: doc/writeback_arbiter_scoreboard.md
Name: writeback_arbiter_scoreboard

Overview:
- Shares the single register-file write port between processor 1 and processor 2 using round-robin arbitration with a req/ack handshake.
- Keeps a per-register busy scoreboard: the multi-processor manager claims a destination register when it boots a processor, and the winning write-back releases it.
- Drives the new_data_register one-hot pulse that the processor manager and both processors consume.

Parameters:
- DATA_WIDTH, 32, register data width.
- REGISTER_AMOUNT, 32, number of architectural registers; register 0 is hard-wired zero.
- ADDR_WIDTH_RF, $clog2(REGISTER_AMOUNT), register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- claim_valid_1  in  1  manager claims a destination register for processor 1 (1-cycle pulse).
- claim_addr_1  in  ADDR_WIDTH_RF  register claimed for processor 1.
- claim_valid_2  in  1  same, processor 2.
- claim_addr_2  in  ADDR_WIDTH_RF  same, processor 2.
- wb_req_1  in  1  processor 1 write-back request; level, held until ack.
- wb_addr_1  in  ADDR_WIDTH_RF  write-back register, stable while req is high.
- wb_data_1  in  DATA_WIDTH  write-back data, stable while req is high.
- wb_ack_1  out  1  1-cycle grant acknowledge to processor 1.
- wb_req_2, wb_addr_2, wb_data_2, wb_ack_2  same set for processor 2.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  ADDR_WIDTH_RF  register-file write address.
- rf_wr_data  out  DATA_WIDTH  register-file write data.
- busy_register  out  REGISTER_AMOUNT  bit i = 1: register i has a pending write.
- new_data_register  out  REGISTER_AMOUNT  one-hot pulse: register written this cycle.
- claim_conflict  out  1  1-cycle pulse on an illegal claim.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, busy vector 0, last_grant=2 so processor 1 wins the first tie. Reset mid-handshake drops the transaction; the requester must re-request.
- Eligibility: eligible_k = wb_req_k & ~wb_ack_k. A requester is never granted in the cycle its ack is high; this absorbs the requester's one-cycle req-drop latency.
- Arbitration, combinational per cycle, at most one grant:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - last_grant updates on every grant.
- Grant registration at edge N+1 after a grant decided in cycle N:
  - wb_ack_k=1 for exactly one cycle.
  - rf_wr_addr and rf_wr_data take the granted requester's inputs.
  - rf_wr_en=1 if addr≠0.
  - new_data_register = (1<<addr) if addr≠0, else 0.
  - Latency request→ack/write = 1 cycle when uncontended.
- Write-back to register 0: acked, no write, no pulse, no busy change.
- No-grant cycle: rf_wr_en=0, new_data_register=0, acks 0; rf_wr_addr and rf_wr_data hold their last values.
- Scoreboard at each edge: busy <= (busy & ~release_mask) | claim_mask.
  - release_mask = one-hot of the write registered at that edge.
  - claim_mask = OR of valid claims; bit 0 is always forced 0.
  - Claim and release of the same register at the same edge: the claim wins and the bit stays 1.
  - busy_register is registered, so it reflects claims one cycle after claim_valid.
- claim_conflict pulses for one cycle, registered, when any of these holds:
  - Both claims are valid with the same nonzero address.
  - A claim targets a register already busy that is not being released at that same edge.
  - The claim is still applied; the bit stays 1.
- Write-back to a non-busy register: performed normally, no error.
- Sustained contention from both processors: grants strictly alternate 1,2,1,2…; each requester gets one ack per two cycles, so there is no starvation.

Test Plan:
- Reset → all outputs 0. Assert wb_req_1 (addr 5, data 0xDEADBEEF) at cycle 0 → cycle 1: wb_ack_1=1, rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, new_data_register=0x00000020.
- Both requesters hold req continuously (addr 3, data 0x11 and addr 4, data 0x22) → writes alternate 3,4,3,4; the first write after reset is from processor 1; acks alternate each cycle.
- claim_valid_1 addr 7 → busy_register bit 7 set the next cycle; a later wb_req_1 addr 7 → bit 7 clears at the same edge as the write.
- At one edge, claim_valid_2 addr 9 while processor 1's write to addr 9 releases → bit 9 remains 1; claim_conflict=0.
- claim_valid_1 and claim_valid_2 both addr 12 → claim_conflict pulses 1 cycle, bit 12 set. wb to addr 0 → ack given, rf_wr_en=0, new_data_register=0.
- Pull rst_n low while req_2 is pending and the ack is due → ack suppressed, busy cleared, all outputs 0 immediately.
